uart_rx_param: RTL

//  Parametrised UART receiver; successor to the fixed 8N1 receiver in the serial debug unit.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selector encodings and the receiver state enum.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BRK_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clock pulse every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Down-counter with terminal-count reload; tick is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= RELOAD;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote, false-start
// rejection, break handling and a valid/ready output register.
//
// state       | meaning
// RX_IDLE     | line idle, waiting for a low sample
// RX_START    | qualifying the start bit by majority vote
// RX_DATA     | shifting in DATA_BITS data bits, LSB first
// RX_PARITY   | sampling and checking the parity bit
// RX_STOP     | sampling stop bit(s); commit at the last stop vote
// RX_BRK_WAIT | line still low after a frame, wait for it to return high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rdy_rx,
    output logic [DATA_BITS-1:0] d_rx,
    output logic                 vld_rx,
    output logic                 frame_err,
    output logic                 par_err,
    output logic                 ovr_err,
    output logic                 busy
);

    localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_V0  = SW'(M - 1);
    localparam logic [SW-1:0] S_V1  = SW'(M);
    localparam logic [SW-1:0] S_V2  = SW'(M + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LOAD  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LOAD = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_param: baud divider DIV=%0d must be >= 2", DIV);
    end

    logic                 tick;
    logic                 sync1;
    logic                 rxs;
    logic                 v0;
    logic                 v1;
    logic                 maj;
    rx_state_t            state;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bit_left;
    logic                 stop_left;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 par_bad;
    logic                 ferr_pend;
    logic                 commit;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser for the asynchronous line, idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Third vote is the live sample at M+1, so the decision needs no extra cycle.
    assign maj = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

    // Receive FSM, advanced on oversample ticks; commit is a one-clock strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            scnt      <= '0;
            v0        <= 1'b1;
            v1        <= 1'b1;
            bit_left  <= '0;
            stop_left <= 1'b0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            ferr_pend <= 1'b0;
            busy      <= 1'b0;
            commit    <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (tick) begin
                if (state != RX_IDLE && state != RX_BRK_WAIT) begin
                    scnt <= (scnt == S_END) ? '0 : scnt + 1'b1;
                    if (scnt == S_V0) v0 <= rxs;
                    if (scnt == S_V1) v1 <= rxs;
                end
                case (state)
                    RX_IDLE: begin
                        if (!rxs) begin
                            scnt  <= '0;
                            state <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (scnt == S_V2) begin
                            if (maj) begin
                                state <= RX_IDLE;
                            end else begin
                                busy      <= 1'b1;
                                par_acc   <= 1'b0;
                                par_bad   <= 1'b0;
                                ferr_pend <= 1'b0;
                            end
                        end
                        if (scnt == S_END) begin
                            state    <= RX_DATA;
                            bit_left <= BIT_LOAD;
                        end
                    end
                    RX_DATA: begin
                        if (scnt == S_V2) begin
                            shreg   <= {maj, shreg[DATA_BITS-1:1]};
                            par_acc <= par_acc ^ maj;
                        end
                        if (scnt == S_END) begin
                            if (bit_left == '0) begin
                                state     <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                                stop_left <= STOP_LOAD;
                            end else begin
                                bit_left <= bit_left - 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (scnt == S_V2) begin
                            // Even: parity bit equals XOR of data; odd: its inverse.
                            par_bad <= (PARITY == PARITY_EVEN) ? (maj != par_acc) : (maj == par_acc);
                        end
                        if (scnt == S_END) state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (scnt == S_V2) begin
                            ferr_pend <= ferr_pend | ~maj;
                            if (stop_left == 1'b0) begin
                                commit <= 1'b1;
                                busy   <= 1'b0;
                                state  <= rxs ? RX_IDLE : RX_BRK_WAIT;
                            end
                        end
                        if (scnt == S_END) stop_left <= 1'b0;
                    end
                    RX_BRK_WAIT: begin
                        if (rxs) state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    // Output register: load on commit unless the previous word is still held.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_rx      <= '0;
            vld_rx    <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            ovr_err <= 1'b0;
            if (commit) begin
                if (!vld_rx || rdy_rx) begin
                    d_rx      <= shreg;
                    frame_err <= ferr_pend;
                    par_err   <= par_bad;
                    vld_rx    <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end else if (vld_rx && rdy_rx) begin
                vld_rx <= 1'b0;
            end
        end
    end

endmodule
